// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN enables multiply early exit once remaining multiplier bits are zero.
module muldiv_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned PW = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t            r_state, w_state_n;
   logic [2:0]        r_f3, w_f3_n;
   logic [XLEN-1:0]   r_b, w_b_n;
   logic [XLEN-1:0]   r_hi, w_hi_n;
   logic [XLEN-1:0]   r_lo, w_lo_n;
   logic [CNT_W-1:0]  r_cnt, w_cnt_n;
   logic              r_neg_p, w_neg_p_n;
   logic              r_neg_r, w_neg_r_n;
   logic              r_busy, w_busy_n;
   logic              r_done, w_done_n;
   logic [XLEN-1:0]   r_result, w_result_n;

   // Operand decode for a new request
   logic            w_a_signed, w_b_signed, w_sa, w_sb, w_div0, w_ovf;
   logic [XLEN-1:0] w_mag_a, w_mag_b;

   assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign w_b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
   assign w_sa       = w_a_signed & op_a[XLEN-1];
   assign w_sb       = w_b_signed & op_b[XLEN-1];
   assign w_mag_a    = w_sa ? (~op_a + XLEN'(1)) : op_a;
   assign w_mag_b    = w_sb ? (~op_b + XLEN'(1)) : op_b;
   assign w_div0     = (op_b == '0);
   assign w_ovf      = w_b_signed & (op_a == MIN_NEG) & (op_b == ALL_ONES);

   // One radix-2 iteration of each datapath
   logic [XLEN:0]   w_sum, w_rs, w_diff;
   logic [XLEN-1:0] w_mul_hi, w_mul_lo;

   assign w_sum    = {1'b0, r_hi} + {1'b0, r_b};
   assign w_mul_hi = r_lo[0] ? w_sum[XLEN:1] : {1'b0, r_hi[XLEN-1:1]};
   assign w_mul_lo = {(r_lo[0] ? w_sum[0] : r_hi[0]), r_lo[XLEN-1:1]};
   assign w_rs     = {r_hi, r_lo[XLEN-1]};
   assign w_diff   = w_rs - {1'b0, r_b};

   logic w_exit_early;
   logic [PW-1:0] w_prod;
`ifdef MULDIV_EARLY_OUT_EN
   // Low r_cnt bits of lo are the multiplier bits not yet consumed
   logic w_rest_zero;
   assign w_rest_zero  = ((r_lo << (CNT_W'(XLEN) - r_cnt)) == '0);
   assign w_exit_early = ~r_f3[2] & w_rest_zero;
   assign w_prod       = {r_hi, r_lo} >> r_cnt;
`else
   assign w_exit_early = 1'b0;
   assign w_prod       = {r_hi, r_lo};
`endif

   // Sign correction and output select
   logic [PW-1:0]   w_prod_s;
   logic [XLEN-1:0] w_q, w_r, w_sel;

   assign w_prod_s = r_neg_p ? (~w_prod + PW'(1)) : w_prod;
   assign w_q      = r_neg_p ? (~r_lo + XLEN'(1)) : r_lo;
   assign w_r      = r_neg_r ? (~r_hi + XLEN'(1)) : r_hi;

   always_comb begin
      unique case (r_f3)
         3'b000:                 w_sel = w_prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_sel = w_prod_s[PW-1:XLEN];
         3'b100, 3'b101:         w_sel = w_q;
         default:                w_sel = w_r;
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      w_state_n  = r_state;
      w_f3_n     = r_f3;
      w_b_n      = r_b;
      w_hi_n     = r_hi;
      w_lo_n     = r_lo;
      w_cnt_n    = r_cnt;
      w_neg_p_n  = r_neg_p;
      w_neg_r_n  = r_neg_r;
      w_busy_n   = r_busy;
      w_done_n   = 1'b0;
      w_result_n = r_result;
      unique case (r_state)
         S_IDLE: begin
            if (start && !r_done) begin
               w_f3_n    = funct3;
               w_busy_n  = 1'b1;
               w_hi_n    = '0;
               w_neg_p_n = w_sa ^ w_sb;
               w_neg_r_n = w_sa;
               w_cnt_n   = CNT_W'(XLEN);
               w_state_n = S_CALC;
               if (funct3[2]) begin
                  w_lo_n = w_mag_a;
                  w_b_n  = w_mag_b;
                  if (w_div0 || w_ovf) begin
                     // Fast paths preload the final q/r unsigned and skip CALC
                     w_hi_n    = w_div0 ? op_a : '0;
                     w_lo_n    = w_div0 ? ALL_ONES : MIN_NEG;
                     w_neg_p_n = 1'b0;
                     w_neg_r_n = 1'b0;
                     w_cnt_n   = '0;
                     w_state_n = S_FIN;
                  end
               end else begin
                  w_lo_n = w_mag_b;
                  w_b_n  = w_mag_a;
`ifdef MULDIV_EARLY_OUT_EN
                  if (w_mag_b == '0) w_state_n = S_FIN;
`endif
               end
            end
         end
         S_CALC: begin
            if (w_exit_early) begin
               w_state_n = S_FIN;
            end else begin
               if (r_f3[2]) begin
                  w_hi_n = w_diff[XLEN] ? w_rs[XLEN-1:0] : w_diff[XLEN-1:0];
                  w_lo_n = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
               end else begin
                  w_hi_n = w_mul_hi;
                  w_lo_n = w_mul_lo;
               end
               w_cnt_n = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) w_state_n = S_FIN;
            end
         end
         S_FIN: begin
            w_result_n = w_sel;
            w_done_n   = 1'b1;
            w_busy_n   = 1'b0;
            w_state_n  = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_f3     <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
         r_neg_p  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_n;
         r_f3     <= w_f3_n;
         r_b      <= w_b_n;
         r_hi     <= w_hi_n;
         r_lo     <= w_lo_n;
         r_cnt    <= w_cnt_n;
         r_neg_p  <= w_neg_p_n;
         r_neg_r  <= w_neg_r_n;
         r_busy   <= w_busy_n;
         r_done   <= w_done_n;
         r_result <= w_result_n;
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand sequences, randomized ops vs arithmetic model.
// Latency is counted in clock edges after the accepting edge N; done in cycle N+k+1 shows up as lat=k.
module tb_muldiv_unit;

   localparam int unsigned XLEN     = 32;
   localparam int          LAT_FULL = XLEN + 1;
   localparam int          LAT_FAST = 1;
   localparam logic [31:0] MINV     = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: RV32M semantics from 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      p  = '0;
      r  = '0;
      case (f3)
         3'd0: begin p = sa * sb; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: if (b == 0) r = '1; else if (a == MINV && b == '1) r = MINV;
               else r = $signed(a) / $signed(b);
         3'd5: if (b == 0) r = '1; else r = a / b;
         3'd6: if (b == 0) r = a; else if (a == MINV && b == '1) r = '0;
               else r = $signed(a) % $signed(b);
         default: if (b == 0) r = a; else r = a % b;
      endcase
      return r;
   endfunction

   function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == MINV && b == '1))) return LAT_FAST;
      return LAT_FULL;
   endfunction

   // Issue one op; optional noisy start during busy and a re-pulse with other operands at lat==rp
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit noisy, input int rp,
                         output logic [31:0] res, output int lat, output int busy_cnt);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      funct3 = f3; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      lat = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (busy && !done) busy_cnt++;
         if (lat == rp) begin
            start = 1'b1; funct3 = 3'd3; op_a = '1; op_b = '1;
         end else begin
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      res = result;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
      end
      chk("busy_at_done", 32'(busy), 32'd0);
      // A start held into the done cycle must be ignored
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("result_held", result, res);
   endtask

   task automatic check_latency(input string name, input logic [2:0] f3, input logic [31:0] b,
                                input int lat, input int exp_lat);
`ifdef MULDIV_EARLY_OUT_EN
      if (!f3[2]) begin
         if (b == 0) chk(name, 32'(lat), 32'(LAT_FAST));
         else        chk(name, 32'(lat <= LAT_FULL), 32'd1);
      end else begin
         chk(name, 32'(lat), 32'(exp_lat));
      end
`else
      chk(name, 32'(lat), 32'(exp_lat));
`endif
   endtask

   initial begin
      vec_t        vecs[15];
      logic [31:0] res;
      int          lat, bcnt, ndone;
      logic [31:0] pool[6];

      vecs[0]  = '{3'd0, 32'd7,         32'd6,         32'd42,        LAT_FULL};
      vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_FULL};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL};
      vecs[3]  = '{3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, LAT_FULL};
      vecs[4]  = '{3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, LAT_FULL};
      vecs[5]  = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, LAT_FAST};
      vecs[6]  = '{3'd7, 32'd100,       32'd0,         32'd100,       LAT_FAST};
      vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST};
      vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_FAST};
      vecs[9]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_FULL};
      vecs[10] = '{3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, LAT_FAST};
      vecs[11] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_FAST};
      vecs[12] = '{3'd0, 32'd5,         32'd0,         32'd0,         LAT_FULL};
      vecs[13] = '{3'd0, 32'd3,         32'd4,         32'd12,        LAT_FULL};
      vecs[14] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, LAT_FULL};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, -1, res, lat, bcnt);
         chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check_latency($sformatf("vec%0d_latency", i), vecs[i].f3, vecs[i].b, lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(lat));
      end

`ifdef MULDIV_EARLY_OUT_EN
      run_op(3'd0, 32'd3, 32'd4, 1'b0, -1, res, lat, bcnt);
      chk("early_out_faster", 32'(lat < LAT_FULL), 32'd1);
`endif

      // Re-pulse start with different operands in cycle N+10: ignored
      run_op(3'd0, 32'd7, 32'd6, 1'b0, 9, res, lat, bcnt);
      chk("repulse_result", res, 32'd42);
      check_latency("repulse_latency", 3'd0, 32'd6, lat, LAT_FULL);

      // Reset asserted in cycle N+15 aborts the operation
      @(negedge clk);
      funct3 = 3'd0; op_a = 32'd9; op_b = 32'h0001_0001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("pre_reset_result_nonzero", 32'(result != 0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      chk("no_done_after_abort", 32'(ndone), 32'd0);

      // Randomized ops against the arithmetic model, with start noise while busy
      pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = MINV;  pool[4] = 32'h7FFF_FFFF; pool[5] = 32'd3;
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int          ia, ib;
         f3 = 3'($urandom_range(0, 7));
         ia = $urandom_range(0, 9);
         ib = $urandom_range(0, 9);
         a  = (ia < 6) ? pool[ia] : $urandom;
         b  = (ib < 6) ? pool[ib] : $urandom;
         run_op(f3, a, b, 1'b1, -1, res, lat, bcnt);
         if (res !== ref_model(f3, a, b))
            $display("  op f3=%0d a=%h b=%h", f3, a, b);
         chk($sformatf("rand%0d_result", i), res, ref_model(f3, a, b));
         check_latency($sformatf("rand%0d_latency", i), f3, b, lat, exp_latency(f3, a, b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
